head_seq: RTL and testbench
===========================

Name: head_seq

Overview:
- Parametrised successor to the fixed 4x4 head.
- Fetches 16-bit instructions from an internal instruction memory and applies tile-wide FP32 bit-level operations on an internal weight memory.
- Weight memory holds TILES tiles of DIM x DIM words.
- Adds start/busy/done handshake, HALT, illegal-opcode error and host load/readback ports.

Parameters:
- DIM, 4, tile edge; tile = DIM*DIM words.
- TILES, 4, number of tiles in weight memory; weight depth = TILES*DIM*DIM.
- IMEM_DEPTH, 64, instruction words; PC width = clog2(IMEM_DEPTH).
- DATA_W, 32, weight word width; sign bit = DATA_W-1.
- ONE_VAL, 32'h3f800000, constant written by FILL_ONE.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin execution at PC=0; sampled only in IDLE
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse on HALT or PC wrap
- err  out  1  sticky; set by illegal opcode or TRANSPOSE src==dst; cleared by start
- pc  out  clog2(IMEM_DEPTH)  current fetch address
- imem_we  in  1  host instruction write; ignored while busy
- imem_addr  in  clog2(IMEM_DEPTH)  host instruction address
- imem_wdata  in  16  host instruction data
- wmem_we  in  1  host weight write; ignored while busy
- wmem_addr  in  clog2(TILES*DIM*DIM)  host weight read/write address
- wmem_wdata  in  DATA_W  host weight data
- wmem_rdata  out  DATA_W  synchronous read of wmem_addr, 1-cycle latency; valid only when not busy

Behaviour:
- Memories are arrays named instrMem.mem and weightMem.mem so benches can preload them hierarchically.
- Reset: state IDLE, pc=0, busy=0, done=0, err=0, wmem_rdata=0. Memory contents are not reset.
- Reset asserted mid-operation aborts immediately. Already-written elements stay written.
- Instruction format: [3:0] opcode, [9:4] src tile, [15:10] dst tile. Tile indices >= TILES are illegal.
- Opcodes:
  - 0 NOP
  - 1 ZERO dst
  - 2 FILL_ONE dst
  - 3 COPY src->dst
  - 4 NEG (flip sign) src->dst
  - 5 RELU (sign=1 -> 0) src->dst
  - 6 ABS (clear sign) src->dst
  - 7 TRANSPOSE src->dst, dst[r][c] = src[c][r]
  - 15 HALT
  - All other opcodes are illegal: set err and execute as NOP.
- FSM: IDLE -> FETCH -> DECODE -> (FILL | READ <-> WRITE | next FETCH) -> ... -> DONE -> IDLE.
  - FETCH: 1 cycle, synchronous imem read.
  - DECODE: 1 cycle.
  - ZERO/FILL_ONE: one write per cycle for DIM*DIM cycles.
  - Unary ops and TRANSPOSE: READ then WRITE per element, 2*DIM*DIM cycles.
  - Element counter runs row-major, 0..DIM*DIM-1.
- In-place operation (src==dst) is legal for ops 3-6: each element is read before it is written.
- TRANSPOSE with src==dst: set err, treat as NOP.
- After the last element, pc increments and the FSM returns to FETCH.
- HALT or pc wrapping past IMEM_DEPTH-1: go to DONE, pulse done, drop busy the same cycle, return to IDLE.
- Start while busy is ignored. Start and host write in the same IDLE cycle: the write takes effect, and fetch sees it.
- NOP/illegal instruction cost: 2 cycles (FETCH + DECODE).

Optional Feature:
- HEAD_SEQ_PERF_EN defined:
  - Adds output perf_cycles (32 bit): counts cycles with busy=1.
  - Clears on accepted start; saturates at 32'hFFFFFFFF.
  - Adds output perf_instrs (16 bit): counts retired instructions, including HALT.
- Undefined: neither port nor counter exists.

Decomposition:
- Package head_seq_pkg holds:
  - opcode localparams (OP_NOP .. OP_HALT);
  - instruction field bit positions;
  - FSM state enum;
  - function tile_base(tile) = tile*DIM*DIM.
- One sub-module, head_seq_agu: element counter plus src/dst address generation, including the transposed source index. Handles start/step/last.

Test Plan:
- Defaults, weights all 3f800000, program {0x0004 (NEG t0->t0), 0x000F}: after done, mem[0..15]=bf800000 and mem[16..63] unchanged. NEG phase takes exactly 32 cycles.
- Program {0x0403 (COPY t0->t1), 0x000F} with mem[i]=i: mem[16+i]=i for i=0..15. done occurs 2+32+2 cycles after the first FETCH.
- Program {0x0417 (TRANSPOSE t1->t1)... actually src=1,dst=1}, then 0x0C07 (TRANSPOSE t0->t3), then HALT: err=1 after the first instruction; mem[48+4r+c]=mem[4c+r].
- Src tile holding {bf800000, 3f800000, 80000000, 00000000}, RELU then ABS: RELU gives {0, 3f800000, 0, 0}; ABS on the original gives {3f800000, 3f800000, 0, 0}.
- Opcode 0x0008, then FILL_ONE t2, then HALT: err=1, tile2 all 3f800000. The next start clears err.
- rst pulsed mid-COPY at element 5: busy=0, pc=0 and done=0 immediately. Elements 0-4 are copied, elements 6-15 are untouched. A fresh start completes normally.

Source files
------------

// File: rtl/head_seq_pkg.sv
// head_seq_pkg: opcodes, instruction field positions, FSM states and tile
// address helper shared by the head_seq sequencer and its address unit.
// No ports; imported by head_seq and head_seq_agu.
package head_seq_pkg;

  // Opcodes, instruction bits [3:0]
  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_ZERO      = 4'd1;
  localparam logic [3:0] OP_FILL_ONE  = 4'd2;
  localparam logic [3:0] OP_COPY      = 4'd3;
  localparam logic [3:0] OP_NEG       = 4'd4;
  localparam logic [3:0] OP_RELU      = 4'd5;
  localparam logic [3:0] OP_ABS       = 4'd6;
  localparam logic [3:0] OP_TRANSPOSE = 4'd7;
  localparam logic [3:0] OP_HALT      = 4'd15;

  // Instruction layout: [3:0] opcode, [9:4] src tile, [15:10] dst tile
  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int SRC_LSB = 4;
  localparam int SRC_MSB = 9;
  localparam int DST_LSB = 10;
  localparam int DST_MSB = 15;
  localparam int TILE_FW = SRC_MSB - SRC_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FILL,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  // First word address of a tile in the weight memory.
  function automatic int tile_base(input int tile, input int dim);
    return tile * dim * dim;
  endfunction

endpackage

// File: rtl/head_seq_agu.sv
// head_seq_agu: row-major element counter and src/dst weight address generator.
// Latency: addresses are combinational from the registered counter; start/step
// take effect on the next clock. No backpressure: step advances unconditionally.
// Ports: clk, rst (async high); start_i latches tiles/transpose and clears the
//   counter; step_i advances one element; src_addr_o/dst_addr_o weight
//   addresses for the current element; last_o marks element DIM*DIM-1.
module head_seq_agu
  import head_seq_pkg::*;
#(
  parameter int DIM = 4,
  parameter int AW  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [TILE_FW-1:0] src_tile_i,
  input  logic [TILE_FW-1:0] dst_tile_i,
  input  logic               transpose_i,
  output logic [AW-1:0]      src_addr_o,
  output logic [AW-1:0]      dst_addr_o,
  output logic               last_o
);

  localparam int RC_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(DIM - 1);

  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;
  logic [AW-1:0]   src_base_q, dst_base_q;
  logic            transpose_q;
  logic [AW-1:0]   lin_idx, tr_idx;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (col_q == RC_LAST) begin
        col_d = '0;
        row_d = (row_q == RC_LAST) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      transpose_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (start_i) begin
        src_base_q  <= AW'(tile_base(int'(src_tile_i), DIM));
        dst_base_q  <= AW'(tile_base(int'(dst_tile_i), DIM));
        transpose_q <= transpose_i;
      end
    end
  end

  // Destination always walks row-major; a transposed source swaps row and col
  // so dst[r][c] picks up src[c][r].
  assign lin_idx    = AW'(int'(row_q) * DIM + int'(col_q));
  assign tr_idx     = AW'(int'(col_q) * DIM + int'(row_q));
  assign dst_addr_o = dst_base_q + lin_idx;
  assign src_addr_o = src_base_q + (transpose_q ? tr_idx : lin_idx);
  assign last_o     = (row_q == RC_LAST) && (col_q == RC_LAST);

endmodule

// File: rtl/head_seq.sv
// head_seq: instruction sequencer applying tile-wide FP32 sign-bit ops to an
// internal weight memory. Latency: 2 cycles per NOP, 2+DIM*DIM for fills,
// 2+2*DIM*DIM for unary/transpose. Host ports are ignored while busy.
// Ports: clk, rst (async high); start/busy/done/err/pc control and status;
//   imem_we/imem_addr/imem_wdata host program load; wmem_we/wmem_addr/
//   wmem_wdata host weight load, wmem_rdata 1-cycle readback (valid when idle).
// Optional: define HEAD_SEQ_PERF_EN to add perf_cycles (busy cycles,
//   saturating) and perf_instrs (retired instructions, HALT included).
module head_seq
  import head_seq_pkg::*;
#(
  parameter int DIM        = 4,
  parameter int TILES      = 4,
  parameter int IMEM_DEPTH = 64,
  parameter int DATA_W     = 32,
  parameter logic [DATA_W-1:0] ONE_VAL = DATA_W'(32'h3f800000),
  localparam int PC_W = $clog2(IMEM_DEPTH),
  localparam int WA_W = $clog2(TILES * DIM * DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PC_W-1:0]    pc,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_wdata,
  input  logic               wmem_we,
  input  logic [WA_W-1:0]    wmem_addr,
  input  logic [DATA_W-1:0]  wmem_wdata,
  output logic [DATA_W-1:0]  wmem_rdata
`ifdef HEAD_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [15:0]        perf_instrs
`endif
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic               pc_wrap;
  logic               err_q, err_d;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               busy_c, done_c;
  logic               fetch_en, agu_start, agu_step, agu_last;
  logic               eng_we, retire, start_acc;
  logic [WA_W-1:0]    src_addr, dst_addr;
  logic [DATA_W-1:0]  eng_wdata;

  logic [3:0]         opc;
  logic [TILE_FW-1:0] src_f, dst_f;
  logic               src_ok, dst_ok;

  logic               im_we;
  logic               wm_we;
  logic [WA_W-1:0]    wm_waddr, wm_raddr;
  logic [DATA_W-1:0]  wm_wdata;

  // instr_q holds the current instruction for the whole execute phase.
  assign opc    = instr_q[OPC_MSB:OPC_LSB];
  assign src_f  = instr_q[SRC_MSB:SRC_LSB];
  assign dst_f  = instr_q[DST_MSB:DST_LSB];
  assign src_ok = {1'b0, src_f} < (TILE_FW + 1)'(TILES);
  assign dst_ok = {1'b0, dst_f} < (TILE_FW + 1)'(TILES);

  assign busy_c  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pc_wrap = (pc_q == PC_W'(IMEM_DEPTH - 1));
  assign pc_inc  = pc_wrap ? '0 : pc_q + PC_W'(1);

  // Memory ports: host owns them while idle, the engine while busy. The single
  // read port doubles as host readback and engine source read.
  assign im_we    = imem_we & ~busy_c;
  assign wm_we    = busy_c ? eng_we    : wmem_we;
  assign wm_waddr = busy_c ? dst_addr  : wmem_addr;
  assign wm_wdata = busy_c ? eng_wdata : wmem_wdata;
  assign wm_raddr = busy_c ? src_addr  : wmem_addr;

  if (1) begin : instrMem
    logic [INSTR_W-1:0] mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
      if (im_we) mem[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           instr_q <= '0;
      else if (fetch_en) instr_q <= mem[pc_q];
    end
  end

  if (1) begin : weightMem
    logic [DATA_W-1:0] mem [TILES * DIM * DIM];

    always_ff @(posedge clk) begin
      if (wm_we) mem[wm_waddr] <= wm_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= mem[wm_raddr];
    end
  end

  head_seq_agu #(
    .DIM (DIM),
    .AW  (WA_W)
  ) u_agu (
    .clk         (clk),
    .rst         (rst),
    .start_i     (agu_start),
    .step_i      (agu_step),
    .src_tile_i  (src_f),
    .dst_tile_i  (dst_f),
    .transpose_i (opc == OP_TRANSPOSE),
    .src_addr_o  (src_addr),
    .dst_addr_o  (dst_addr),
    .last_o      (agu_last)
  );

  // Element transform; in WRITE rdata_q holds the source word read in READ.
  always_comb begin
    eng_wdata = rdata_q;
    case (opc)
      OP_ZERO:     eng_wdata = '0;
      OP_FILL_ONE: eng_wdata = ONE_VAL;
      OP_NEG:      eng_wdata = {~rdata_q[DATA_W-1], rdata_q[DATA_W-2:0]};
      OP_RELU:     eng_wdata = rdata_q[DATA_W-1] ? '0 : rdata_q;
      OP_ABS:      eng_wdata = {1'b0, rdata_q[DATA_W-2:0]};
      default:     ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    fetch_en  = 1'b0;
    agu_start = 1'b0;
    agu_step  = 1'b0;
    eng_we    = 1'b0;
    retire    = 1'b0;
    start_acc = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          pc_d      = '0;
          err_d     = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        fetch_en = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        // Default: instruction retires here and the PC advances.
        retire  = 1'b1;
        pc_d    = pc_inc;
        state_d = pc_wrap ? S_DONE : S_FETCH;
        case (opc)
          OP_NOP: ;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_DONE;
          end
          OP_ZERO, OP_FILL_ONE: begin
            if (dst_ok) begin
              retire    = 1'b0;
              pc_d      = pc_q;
              agu_start = 1'b1;
              state_d   = S_FILL;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_COPY, OP_NEG, OP_RELU, OP_ABS, OP_TRANSPOSE: begin
            // An in-place transpose would overwrite elements still to be read.
            if (src_ok && dst_ok && !(opc == OP_TRANSPOSE && src_f == dst_f)) begin
              retire    = 1'b0;
              pc_d      = pc_q;
              agu_start = 1'b1;
              state_d   = S_READ;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end

      S_FILL: begin
        eng_we   = 1'b1;
        agu_step = 1'b1;
        if (agu_last) begin
          retire  = 1'b1;
          pc_d    = pc_inc;
          state_d = pc_wrap ? S_DONE : S_FETCH;
        end
      end

      S_READ: begin
        state_d = S_WRITE;
      end

      S_WRITE: begin
        eng_we   = 1'b1;
        agu_step = 1'b1;
        if (agu_last) begin
          retire  = 1'b1;
          pc_d    = pc_inc;
          state_d = pc_wrap ? S_DONE : S_FETCH;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign busy       = busy_c;
  assign done       = done_c;
  assign err        = err_q;
  assign pc         = pc_q;
  assign wmem_rdata = rdata_q;

`ifdef HEAD_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_instrs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_instrs_q <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_instrs_q <= '0;
    end else begin
      if (busy_c && perf_cycles_q != 32'hFFFF_FFFF) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (retire) perf_instrs_q <= perf_instrs_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_instrs = perf_instrs_q;
`endif

endmodule

// File: tb/tb_head_seq.sv
module tb_head_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  pc;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        wmem_we;
  logic [5:0]  wmem_addr;
  logic [31:0] wmem_wdata;
  logic [31:0] wmem_rdata;
`ifdef HEAD_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_instrs;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  head_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .wmem_we    (wmem_we),
    .wmem_addr  (wmem_addr),
    .wmem_wdata (wmem_wdata),
    .wmem_rdata (wmem_rdata)
`ifdef HEAD_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instrs (perf_instrs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic imem_wr(input int a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_addr  = 6'(a);
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic wmem_wr(input int a, input logic [31:0] d);
    wmem_we    = 1'b1;
    wmem_addr  = 6'(a);
    wmem_wdata = d;
    tick();
    wmem_we    = 1'b0;
  endtask

  // mode 0: every word 3f800000; mode 1: word i holds i
  task automatic load_w(input int mode);
    for (int i = 0; i < 64; i++) wmem_wr(i, (mode == 0) ? 32'h3f800000 : 32'(i));
  endtask

  // Accept start; afterwards cyc==0 is the first FETCH cycle.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    while (done !== 1'b1 && cyc < limit) tick();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] wm(input int a);
    return dut.weightMem.mem[a];
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0;
    imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    wmem_we = 1'b0; wmem_addr = '0; wmem_wdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_rdata", wmem_rdata, 32'd0);

    // NEG t0->t0 in place; host write while busy must be dropped
    load_w(0);
    imem_wr(0, 16'h0004);
    imem_wr(1, 16'h000F);
    go();
    chk("neg_busy_c0", 32'(busy), 32'd1);
    chk("neg_pc_c0", 32'(pc), 32'd0);
    repeat (5) tick();
    wmem_wr(40, 32'hDEADBEEF);
    wait_done("neg", 300);
    chk("neg_done_cycle", 32'(cyc), 32'd36);
    chk("neg_busy_at_done", 32'(busy), 32'd0);
    chk("neg_err", 32'(err), 32'd0);
    tick();
    chk("neg_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("neg_t0[%0d]", i), wm(i), 32'hbf800000);
    for (int i = 16; i < 64; i++) chk($sformatf("neg_rest[%0d]", i), wm(i), 32'h3f800000);
    wmem_addr = 6'd3;
    tick();
    chk("rdata_3", wmem_rdata, 32'hbf800000);
    wmem_addr = 6'd40;
    tick();
    chk("rdata_40", wmem_rdata, 32'h3f800000);

    // COPY t0->t1
    load_w(1);
    imem_wr(0, 16'h0403);
    imem_wr(1, 16'h000F);
    go();
    wait_done("copy", 300);
    chk("copy_done_cycle", 32'(cyc), 32'd36);
    for (int i = 0; i < 16; i++) chk($sformatf("copy_t1[%0d]", i), wm(16 + i), 32'(i));
    chk("copy_t0_kept", wm(7), 32'd7);

    // TRANSPOSE t1->t1 (error, NOP) then TRANSPOSE t0->t3
    load_w(1);
    imem_wr(0, 16'h0417);
    imem_wr(1, 16'h0C07);
    imem_wr(2, 16'h000F);
    go();
    tick();
    chk("tr_err_c1", 32'(err), 32'd0);
    tick();
    chk("tr_err_c2", 32'(err), 32'd1);
    chk("tr_pc_c2", 32'(pc), 32'd1);
    wait_done("tr", 300);
    chk("tr_done_cycle", 32'(cyc), 32'd38);
    chk("tr_err_end", 32'(err), 32'd1);
    for (int i = 0; i < 16; i++) chk($sformatf("tr_t1[%0d]", i), wm(16 + i), 32'(16 + i));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("tr_t3[%0d][%0d]", r, c), wm(48 + 4 * r + c), 32'(4 * c + r));

    // RELU t0->t1, ABS t0->t2
    load_w(1);
    wmem_wr(0, 32'hbf800000);
    wmem_wr(1, 32'h3f800000);
    wmem_wr(2, 32'h80000000);
    wmem_wr(3, 32'h00000000);
    imem_wr(0, 16'h0405);
    imem_wr(1, 16'h0806);
    imem_wr(2, 16'h000F);
    go();
    wait_done("ra", 400);
    chk("ra_done_cycle", 32'(cyc), 32'd70);
    chk("relu_0", wm(16), 32'h00000000);
    chk("relu_1", wm(17), 32'h3f800000);
    chk("relu_2", wm(18), 32'h00000000);
    chk("relu_3", wm(19), 32'h00000000);
    chk("relu_4", wm(20), 32'd4);
    chk("abs_0", wm(32), 32'h3f800000);
    chk("abs_1", wm(33), 32'h3f800000);
    chk("abs_2", wm(34), 32'h00000000);
    chk("abs_3", wm(35), 32'h00000000);
    chk("abs_src_kept", wm(0), 32'hbf800000);

    // Illegal opcode, FILL_ONE t2, HALT; start while busy is ignored
    load_w(1);
    imem_wr(0, 16'h0008);
    imem_wr(1, 16'h0802);
    imem_wr(2, 16'h000F);
    go();
    tick(); tick();
    chk("ill_err_c2", 32'(err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ill", 300);
    chk("ill_done_cycle", 32'(cyc), 32'd22);
    chk("ill_err_end", 32'(err), 32'd1);
    for (int i = 0; i < 16; i++) chk($sformatf("fill_t2[%0d]", i), wm(32 + i), 32'h3f800000);
    chk("fill_t1_kept", wm(16), 32'd16);
`ifdef HEAD_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, 32'd22);
    chk("perf_instrs", 32'(perf_instrs), 32'd3);
`endif
    tick();
    go();
    chk("ill_err_cleared_c0", 32'(err), 32'd0);
    tick();
    chk("ill_err_cleared_c1", 32'(err), 32'd0);
    wait_done("ill2", 300);
    chk("ill2_done_cycle", 32'(cyc), 32'd22);

    // 64 NOPs: PC wraps past the last word and ends the run
    for (int i = 0; i < 64; i++) imem_wr(i, 16'h0000);
    go();
    wait_done("wrap", 400);
    chk("wrap_done_cycle", 32'(cyc), 32'd128);
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_err", 32'(err), 32'd0);

    // Reset during COPY element 5 (READ of element 5 is cycle 12)
    load_w(1);
    imem_wr(0, 16'h0403);
    imem_wr(1, 16'h000F);
    go();
    while (cyc < 12) tick();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("mid_copied[%0d]", i), wm(16 + i), 32'(i));
    for (int i = 5; i < 16; i++) chk($sformatf("mid_untouched[%0d]", i), wm(16 + i), 32'(16 + i));
    go();
    wait_done("after_rst", 300);
    chk("after_rst_done_cycle", 32'(cyc), 32'd36);
    for (int i = 0; i < 16; i++) chk($sformatf("after_rst_t1[%0d]", i), wm(16 + i), 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
